// File: rtl/reg_load_arbiter_pkg.sv
// Shared definitions for the two-requester register-load arbiter:
// FSM state encoding and default widths.
package reg_load_arbiter_pkg;

  localparam int N_DEFAULT  = 4;
  localparam int CW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ACK  = 2'b10
  } state_e;

endpackage : reg_load_arbiter_pkg

// File: rtl/reg_load_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that is
// not the current owner wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic owner,
  output logic grant,
  output logic valid
);

  // Tie goes to the non-owner; a lone request wins outright.
  always_comb begin
    valid = req0 | req1;
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~owner;
    end else if (req1) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

endmodule : rr_pick2

// File: rtl/reg_load_arbiter.sv
// Shares one external loadable register between two requesters: picks a
// winner, drives d/load for one clock, then acks and counts the load.
module reg_load_arbiter
  import reg_load_arbiter_pkg::*;
#(
  parameter int n  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          ck,
  input  logic          reset,
  input  logic          req0,
  input  logic [n-1:0]  d0,
  input  logic          req1,
  input  logic [n-1:0]  d1,
  output logic          ack0,
  output logic          ack1,
  output logic          load,
  output logic [n-1:0]  d,
  output logic          busy,
  output logic          owner,
  output logic [CW-1:0] nloads
);

  state_e          state_q;
  logic            load_q;
  logic            ack0_q;
  logic            ack1_q;
  logic            busy_q;
  logic            owner_q;
  logic [n-1:0]    d_q;
  logic [CW-1:0]   nloads_q;
  logic [CW-1:0]   nloads_d;
  logic            pick_grant;
  logic            pick_valid;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .owner (owner_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Counter wraps silently at 2^CW.
  assign nloads_d = nloads_q + CW'(1'b1);

  // Arbitration FSM with all outputs registered; owner resets to 1 so
  // requester 0 wins the first tie.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      owner_q  <= 1'b1;
      d_q      <= '0;
      nloads_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (pick_valid) begin
            state_q <= LOAD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            owner_q <= pick_grant;
            d_q     <= pick_grant ? d1 : d0;
          end else begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        LOAD: begin
          // Register captures d on this edge; ack goes to the owner.
          state_q <= ACK;
          load_q  <= 1'b0;
          ack0_q  <= ~owner_q;
          ack1_q  <= owner_q;
          busy_q  <= 1'b1;
        end
        ACK: begin
          state_q  <= IDLE;
          load_q   <= 1'b0;
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          busy_q   <= 1'b0;
          nloads_q <= nloads_d;
        end
        default: begin
          state_q <= IDLE;
          load_q  <= 1'b0;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign load   = load_q;
  assign d      = d_q;
  assign busy   = busy_q;
  assign owner  = owner_q;
  assign nloads = nloads_q;

endmodule : reg_load_arbiter

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter: a cycle table plus hand sequences for
// async reset, counter wrap (CW=2 instance) and a late request during ACK.
module tb_reg_load_arbiter;

  logic       ck;
  logic       reset;
  logic       req0, req1;
  logic [3:0] d0, d1;
  logic       ack0, ack1, load, busy, owner;
  logic [3:0] d;
  logic [7:0] nloads;
  logic       ack0_2, ack1_2, load_2, busy_2, owner_2;
  logic [3:0] d_2;
  logic [1:0] nloads_2;
  logic [3:0] q;

  int total = 0;
  int bad   = 0;

  reg_load_arbiter #(.n(4), .CW(8)) dut (
    .ck(ck), .reset(reset), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .ack0(ack0), .ack1(ack1), .load(load), .d(d), .busy(busy),
    .owner(owner), .nloads(nloads)
  );

  reg_load_arbiter #(.n(4), .CW(2)) dut2 (
    .ck(ck), .reset(reset), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .ack0(ack0_2), .ack1(ack1_2), .load(load_2), .d(d_2), .busy(busy_2),
    .owner(owner_2), .nloads(nloads_2)
  );

  // The shared register driven by the arbiter.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) q <= 4'h0;
    else if (load) q <= d;
  end

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic       rst;
    logic       r0;
    logic [3:0] v0;
    logic       r1;
    logic [3:0] v1;
    logic       e_load;
    logic [3:0] e_d;
    logic       e_a0;
    logic       e_a1;
    logic       e_busy;
    logic       e_owner;
    logic [7:0] e_nl;
    logic [3:0] e_q;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    //          rst r0 v0    r1 v1    load d     a0 a1 busy own nl     q
    tbl[0]  = '{1'b1,1'b0,4'h0,1'b0,4'h0, 1'b0,4'h0,1'b0,1'b0,1'b0,1'b1,8'd0,4'h0};
    tbl[1]  = '{1'b0,1'b1,4'h5,1'b0,4'h0, 1'b1,4'h5,1'b0,1'b0,1'b1,1'b0,8'd0,4'h0};
    tbl[2]  = '{1'b0,1'b1,4'h5,1'b0,4'h0, 1'b0,4'h5,1'b1,1'b0,1'b1,1'b0,8'd0,4'h5};
    tbl[3]  = '{1'b0,1'b0,4'h0,1'b0,4'h0, 1'b0,4'h5,1'b0,1'b0,1'b0,1'b0,8'd1,4'h5};
    tbl[4]  = '{1'b0,1'b0,4'hF,1'b0,4'hF, 1'b0,4'h5,1'b0,1'b0,1'b0,1'b0,8'd1,4'h5};
    tbl[5]  = '{1'b0,1'b0,4'h0,1'b1,4'h9, 1'b1,4'h9,1'b0,1'b0,1'b1,1'b1,8'd1,4'h5};
    tbl[6]  = '{1'b0,1'b0,4'h0,1'b1,4'h9, 1'b0,4'h9,1'b0,1'b1,1'b1,1'b1,8'd1,4'h9};
    tbl[7]  = '{1'b0,1'b0,4'h0,1'b0,4'h0, 1'b0,4'h9,1'b0,1'b0,1'b0,1'b1,8'd2,4'h9};
    tbl[8]  = '{1'b1,1'b0,4'h0,1'b0,4'h0, 1'b0,4'h0,1'b0,1'b0,1'b0,1'b1,8'd0,4'h0};
    tbl[9]  = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b1,4'h3,1'b0,1'b0,1'b1,1'b0,8'd0,4'h0};
    tbl[10] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b0,4'h3,1'b1,1'b0,1'b1,1'b0,8'd0,4'h3};
    tbl[11] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b0,4'h3,1'b0,1'b0,1'b0,1'b0,8'd1,4'h3};
    tbl[12] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b1,4'hC,1'b0,1'b0,1'b1,1'b1,8'd1,4'h3};
    tbl[13] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b0,4'hC,1'b0,1'b1,1'b1,1'b1,8'd1,4'hC};
    tbl[14] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b0,4'hC,1'b0,1'b0,1'b0,1'b1,8'd2,4'hC};
    tbl[15] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b1,4'h3,1'b0,1'b0,1'b1,1'b0,8'd2,4'hC};
    tbl[16] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b0,4'h3,1'b1,1'b0,1'b1,1'b0,8'd2,4'h3};
    tbl[17] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b0,4'h3,1'b0,1'b0,1'b0,1'b0,8'd3,4'h3};
    tbl[18] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b1,4'hC,1'b0,1'b0,1'b1,1'b1,8'd3,4'h3};
    tbl[19] = '{1'b0,1'b1,4'h3,1'b1,4'hC, 1'b0,4'hC,1'b0,1'b1,1'b1,1'b1,8'd3,4'hC};
    tbl[20] = '{1'b0,1'b0,4'h0,1'b0,4'h0, 1'b0,4'hC,1'b0,1'b0,1'b0,1'b1,8'd4,4'hC};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 4'h0; d1 = 4'h0;
    #1;
    chk("t0_load", 32'(load), 32'd0);
    chk("t0_ack0", 32'(ack0), 32'd0);
    chk("t0_ack1", 32'(ack1), 32'd0);
    chk("t0_d", 32'(d), 32'd0);
    chk("t0_nloads", 32'(nloads), 32'd0);
    chk("t0_busy", 32'(busy), 32'd0);
    chk("t0_owner", 32'(owner), 32'd1);

    for (int i = 0; i < 21; i++) begin
      @(negedge ck);
      reset = tbl[i].rst;
      req0 = tbl[i].r0; d0 = tbl[i].v0;
      req1 = tbl[i].r1; d1 = tbl[i].v1;
      @(posedge ck);
      #1;
      chk($sformatf("row%0d_load", i), 32'(load), 32'(tbl[i].e_load));
      chk($sformatf("row%0d_d", i), 32'(d), 32'(tbl[i].e_d));
      chk($sformatf("row%0d_ack0", i), 32'(ack0), 32'(tbl[i].e_a0));
      chk($sformatf("row%0d_ack1", i), 32'(ack1), 32'(tbl[i].e_a1));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d_owner", i), 32'(owner), 32'(tbl[i].e_owner));
      chk($sformatf("row%0d_nloads", i), 32'(nloads), 32'(tbl[i].e_nl));
      chk($sformatf("row%0d_q", i), 32'(q), 32'(tbl[i].e_q));
      chk($sformatf("row%0d_nloads2", i), 32'(nloads_2), 32'(tbl[i].e_nl[1:0]));
      chk($sformatf("row%0d_load2", i), 32'(load_2), 32'(tbl[i].e_load));
    end

    // Reset asserted during LOAD: load drops at once, no ack, no count.
    @(negedge ck); reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge ck); reset = 1'b0; req0 = 1'b1; d0 = 4'h9;
    @(posedge ck); #1;
    chk("rst_pre_load", 32'(load), 32'd1);
    chk("rst_pre_d", 32'(d), 32'h9);
    @(negedge ck); reset = 1'b1;
    #1;
    chk("rst_async_load", 32'(load), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_ack0", 32'(ack0), 32'd0);
    chk("rst_async_nloads", 32'(nloads), 32'd0);
    @(posedge ck); #1;
    chk("rst_hold_ack0", 32'(ack0), 32'd0);
    @(negedge ck); reset = 1'b0; req0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge ck); #1;
      chk($sformatf("rst_after%0d_ack0", k), 32'(ack0), 32'd0);
      chk($sformatf("rst_after%0d_load", k), 32'(load), 32'd0);
      chk($sformatf("rst_after%0d_nloads", k), 32'(nloads), 32'd0);
      chk($sformatf("rst_after%0d_q", k), 32'(q), 32'd0);
    end

    // Back-to-back single-requester loads: CW=2 counter wraps 1,2,3,0.
    @(negedge ck); reset = 1'b1;
    @(negedge ck); reset = 1'b0; req0 = 1'b1; d0 = 4'h7;
    for (int k = 1; k <= 4; k++) begin
      repeat (3) @(posedge ck);
      #1;
      chk($sformatf("wrap%0d_nloads2", k), 32'(nloads_2), 32'(k % 4));
      chk($sformatf("wrap%0d_nloads", k), 32'(nloads), 32'(k));
      chk($sformatf("wrap%0d_q", k), 32'(q), 32'h7);
    end
    @(negedge ck); req0 = 1'b0;
    @(posedge ck); #1;

    // Requester 1 pulses only inside requester 0's ACK cycle: dropped.
    @(negedge ck); req0 = 1'b1; d0 = 4'h6;
    @(posedge ck); #1;
    chk("late_load", 32'(load), 32'd1);
    chk("late_owner", 32'(owner), 32'd0);
    @(posedge ck); #1;
    chk("late_ack0", 32'(ack0), 32'd1);
    chk("late_ack1", 32'(ack1), 32'd0);
    @(negedge ck); req0 = 1'b0; req1 = 1'b1; d1 = 4'hA;
    #2; req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge ck); #1;
      chk($sformatf("late%0d_load", k), 32'(load), 32'd0);
      chk($sformatf("late%0d_ack1", k), 32'(ack1), 32'd0);
      chk($sformatf("late%0d_owner", k), 32'(owner), 32'd0);
      chk($sformatf("late%0d_d", k), 32'(d), 32'h6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule : tb_reg_load_arbiter

// File: doc/reg_load_arbiter.md
Name: reg_load_arbiter

Overview:
- Shares one n-bit loadable register (d/load/q datapath) between two requesters.
- Arbitrates round-robin, captures the winner's data, and drives d/load to the register for exactly one clock.
- Acknowledges the winner after the load edge and counts completed loads.
- Sits between requester logic and the register instance; the register itself stays external.

Parameters:
- n, 4, data width of the shared register and of each requester's data.
- CW, 8, width of the completed-load counter.

Ports:
- ck  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 wants a load; held high until ack0.
- d0  input  n  requester 0 data; stable while req0 is high.
- req1  input  1  requester 1 wants a load; held high until ack1.
- d1  input  n  requester 1 data; stable while req1 is high.
- ack0  output  1  one-cycle pulse: requester 0's data has been loaded.
- ack1  output  1  one-cycle pulse: requester 1's data has been loaded.
- load  output  1  to register load input.
- d  output  n  to register data input.
- busy  output  1  high in LOAD and ACK states.
- owner  output  1  index of the most recently granted requester.
- nloads  output  CW  count of completed loads.

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately, without waiting for ck:
  - state=IDLE; load=0, ack0=ack1=0, busy=0.
  - d=0, owner=1, so requester 0 wins the first tie.
  - nloads=0.
- Reset mid-operation aborts the transaction: no ack is issued and nloads does not increment.
- States: IDLE, LOAD, ACK; all outputs are registered.
- IDLE transitions:
  - No request: stay in IDLE; d holds its last value.
  - Only reqX high: grant X.
  - Both high: grant the requester that is not owner (round-robin).
  - On grant: d<=dX, owner<=X, load<=1, go to LOAD.
- LOAD (one cycle):
  - load=1 and d is stable for the whole cycle.
  - The register captures d on the rising edge that ends this cycle.
  - Next: load<=0, ackX<=1, go to ACK.
- ACK (one cycle):
  - ackX=1.
  - nloads<=nloads+1, modulo 2^CW; wraps from all-ones to 0 silently.
  - Next: ackX<=0, go to IDLE.
- Timing:
  - Latency from req sampled high in IDLE to ack: 2 cycles.
  - Maximum throughput: one load per 3 cycles.
- Requester handshake:
  - The requester deasserts reqX on the edge after it sees ackX.
  - A reqX still high when IDLE is re-entered is treated as a new request.
- A req that falls before it is granted is dropped with no side effect.
- A request from the non-owner arriving during LOAD/ACK waits and is served on the next IDLE cycle.
- load is never high for more than one consecutive cycle; ack0 and ack1 are never high together.
- d changes only on the IDLE->LOAD edge.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, LOAD=2'b01, ACK=2'b10; the unused code 2'b11 returns to IDLE.
  - default width constants n=4, CW=8.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker.
  - Inputs: req0, req1, owner.
  - Outputs: grant, valid.
- The FSM, data mux/capture register and counter stay in the top block.
- The bench instantiates this block with the existing clock generator and register module, connecting load, d and q.

Test Plan:
- Reset at t=0, then release: load=0, ack0=ack1=0, d=0000, nloads=0, busy=0.
- req0=1, d0=0101 alone:
  - load=1 with d=0101 for exactly one cycle.
  - Register q=0101 after that edge; ack0 pulses on the next cycle.
  - nloads=1, owner=0.
- req0 and req1 both held continuously, d0=0011, d1=1100, starting with owner=1:
  - Grants alternate 0,1,0,1; q sequence 0011,1100,0011,1100.
  - One load every 3 cycles; ack0 and ack1 never overlap.
- reset asserted during LOAD:
  - load falls immediately, with no ack.
  - nloads stays at its prior value; state=IDLE.
- CW=2, four back-to-back single-requester loads: nloads sequence 1,2,3,0.
- req1 raised and dropped while in ACK for requester 0: no grant to 1 and load stays 0 afterward.
